cla_multiword_add_ctrl: RTL and testbench

//   Sequencer that reuses one CarryLookAhead_Adder instance to add two W = N*K bit

---
 rtl/cla_multiword_add_ctrl_pkg.sv | 7 +
 rtl/cla_multiword_add_ctrl_if.sv | 11 +
 rtl/cla_multiword_add_ctrl_cla.sv | 26 ++
 rtl/cla_multiword_add_ctrl.sv | 54 +++++
 tb/tb_cla_multiword_add_ctrl.sv | 103 ++++++++++
 5 files changed

// File: rtl/cla_multiword_add_ctrl_pkg.sv
// cla_ctrl_pkg: shared FSM state encoding and index-width helper for the multiword CLA sequencer
package cla_ctrl_pkg;
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_ADD = 2'd1, ST_DONE = 2'd2} state_t;
  function automatic int idx_w(input int k);
    return k > 1 ? $clog2(k) : 1;
  endfunction
endpackage

// File: rtl/cla_multiword_add_ctrl_if.sv
// cla_multiword_add_ctrl_if: request/result bundle (start, num1, num2 in; busy, done, result out)
interface cla_multiword_add_ctrl_if #(parameter int N = 8, parameter int K = 4);
  logic start;
  logic [N*K-1:0] num1;
  logic [N*K-1:0] num2;
  logic busy;
  logic done;
  logic [N*K:0] result;
  modport master(output start, num1, num2, input busy, done, result);
  modport slave(input start, num1, num2, output busy, done, result);
endinterface

// File: rtl/cla_multiword_add_ctrl_cla.sv
// CarryLookAhead_Adder: combinational N-bit carry-lookahead adder, no carry-in; ports num1, num2 in, sum (N+1 bits) out
module CarryLookAhead_Adder #(parameter int N = 9) (
  input  logic [N-1:0] num1,
  input  logic [N-1:0] num2,
  output logic [N:0]   sum
);
  logic [N-1:0] g, p;
  logic [N:0] c;
  logic t;
  assign g = num1 & num2;
  assign p = num1 ^ num2;
  // each carry expanded as a flat sum of generate terms gated by the propagates above them
  always_comb begin
    c = '0;
    t = 1'b0;
    for (int i = 0; i < N; i++) begin
      c[i+1] = g[i];
      t = p[i];
      for (int j = i - 1; j >= 0; j--) begin
        c[i+1] = c[i+1] | (t & g[j]);
        t = t & p[j];
      end
    end
  end
  assign sum = {c[N], p ^ c[N-1:0]};
endmodule

// File: rtl/cla_multiword_add_ctrl.sv
// cla_multiword_add_ctrl: adds two N*K-bit operands one N-bit chunk per clock through one shared CLA; ports clk, rst, bus (slave: start/num1/num2 in, busy/done/result out)
module cla_multiword_add_ctrl
  import cla_ctrl_pkg::*;
#(parameter int N = 8, parameter int K = 4) (
  input logic clk,
  input logic rst,
  cla_multiword_add_ctrl_if.slave bus
);
  localparam int W = N * K;
  localparam int IW = idx_w(K);
  state_t state, state_nx;
  logic [IW-1:0] idx;
  logic carry;
  logic [W-1:0] opa, opb;
  logic [W:0] result;
  logic [N+1:0] s;
  logic last;
  logic unused_s0;
  // a forced 1 in the LSB of num1 turns cin into a carry into bit 1, so s[N+1:1] = a + b + cin
  CarryLookAhead_Adder #(.N(N + 1)) u_cla (
    .num1({opa[idx*N +: N], 1'b1}),
    .num2({opb[idx*N +: N], carry}),
    .sum (s)
  );
  assign unused_s0 = s[0];
  assign last = idx == IW'(K - 1);
  always_comb state_nx = state == ST_IDLE ? (bus.start ? ST_ADD : ST_IDLE) :
                         state == ST_ADD  ? (last ? ST_DONE : ST_ADD) : ST_IDLE;
  always_ff @(posedge clk)
    if (rst) state <= ST_IDLE;
    else state <= state_nx;
  always_ff @(posedge clk) begin
    if (rst) begin
      idx <= '0;
      carry <= 1'b0;
      opa <= '0;
      opb <= '0;
      result <= '0;
    end else if (state == ST_IDLE && bus.start) begin
      opa <= bus.num1;
      opb <= bus.num2;
      idx <= '0;
      carry <= 1'b0;
    end else if (state == ST_ADD) begin
      result[idx*N +: N] <= s[N:1];
      carry <= s[N+1];
      idx <= idx + 1'b1;
      if (last) result[W] <= s[N+1];
    end
  end
  assign bus.busy = state != ST_IDLE;
  assign bus.done = state == ST_DONE;
  assign bus.result = result;
endmodule

// File: tb/tb_cla_multiword_add_ctrl.sv
// tb_cla_multiword_add_ctrl: directed and randomized checks of the multiword adder against plain wide addition
module tb_cla_multiword_add_ctrl;
  localparam int N = 8;
  localparam int K = 4;
  localparam int W = N * K;
  logic clk = 1'b0;
  logic rst;
  int checks = 0;
  int passes = 0;
  always #5 clk = ~clk;
  cla_multiword_add_ctrl_if #(.N(N), .K(K)) bus();
  cla_multiword_add_ctrl #(.N(N), .K(K)) dut(.clk(clk), .rst(rst), .bus(bus));
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask
  task automatic op(input logic [W-1:0] a, input logic [W-1:0] b, input bit mid);
    logic [W:0] exp;
    int done_at;
    int dones;
    int busy_n;
    exp = {1'b0, a} + {1'b0, b};
    done_at = -1;
    dones = 0;
    busy_n = 1;
    bus.start = 1'b1;
    bus.num1 = a;
    bus.num2 = b;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.num1 = $urandom;
    bus.num2 = $urandom;
    check("busy_on_accept", 64'(bus.busy), 64'd1);
    for (int i = 1; i <= K + 1; i++) begin
      if (mid && i == 1) begin
        bus.start = 1'b1;
        bus.num1 = '1;
        bus.num2 = '1;
      end
      @(posedge clk); #1;
      if (mid && i == 1) bus.start = 1'b0;
      busy_n += int'(bus.busy);
      if (bus.done) begin
        dones++;
        if (done_at < 0) begin
          done_at = i;
          check("result", 64'(bus.result), 64'(exp));
        end
      end
    end
    check("done_at", 64'(done_at), 64'(K));
    check("done_count", 64'(dones), 64'd1);
    check("busy_cycles", 64'(busy_n), 64'(K + 1));
    repeat (2) @(posedge clk);
    #1;
    check("result_hold", 64'(bus.result), 64'(exp));
  endtask
  initial begin
    int dones;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.num1 = '0;
    bus.num2 = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    check("rst_result", 64'(bus.result), 64'd0);
    rst = 1'b0;
    op(32'h00000000, 32'h00000000, 1'b0);
    op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
    op(32'hFFFFFFFF, 32'h00000001, 1'b0);
    op(32'h12345678, 32'h0FEDCBA9, 1'b0);
    op(32'h000000FF, 32'h00000001, 1'b1);
    bus.start = 1'b1;
    bus.num1 = 32'hFFFFFFFF;
    bus.num2 = 32'h00000001;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_busy", 64'(bus.busy), 64'd0);
    check("midrst_done", 64'(bus.done), 64'd0);
    check("midrst_result", 64'(bus.result), 64'd0);
    dones = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      dones += int'(bus.done);
    end
    check("midrst_no_done", 64'(dones), 64'd0);
    op(32'h00000003, 32'h00000004, 1'b0);
    for (int i = 0; i < 16; i++) begin
      op($urandom, $urandom, 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
